// File: rtl/nmr_bstrm_simp_cnt.sv
// rtl/nmr_bstrm_simp_cnt.sv - SRAM-driven NMR pulse bitstream generator
// Walks a 32-bit command list from SRAM, driving OUT per segment with one-level looping.
module nmr_bstrm_simp_cnt #(
  parameter int CMD_WIDTH       = 8,
  parameter int LOOP_WIDTH      = 24,
  parameter int SRAM_ADDR_WIDTH = 8,
  parameter int SRAM_DAT_WIDTH  = 32,
  parameter int DATA_WIDTH      = 24,
  parameter int MUX_WIDTH       = 16
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       START,
  output logic                       DONE,
  output logic                       OUT,
  output logic [SRAM_ADDR_WIDTH-1:0] SRAM_ADDR,
  input  logic [SRAM_DAT_WIDTH-1:0]  SRAM_RD_DAT,
  output logic                       sim_changed_sram_addr
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    W1    = 2'd1,
    W2    = 2'd2,
    COUNT = 2'd3
  } state_t;

  state_t                     state, state_d;
  logic [CMD_WIDTH-1:0]       ptr, ptr_d, ptr_inc;
  logic [CMD_WIDTH-1:0]       loop_addr, loop_addr_d;
  logic [LOOP_WIDTH-1:0]      loop_cnt, loop_cnt_d;
  logic [DATA_WIDTH-1:0]      cnt, cnt_d;
  logic [MUX_WIDTH-1:0]       mux_onehot, mux_onehot_d;
  logic                       loop_sto, loop_sto_d;
  logic                       out_d, done_d;
  logic [SRAM_ADDR_WIDTH-1:0] addr_inc;

  logic                       w_pol, w_end, w_lsta, w_lsto;
  logic [3:0]                 w_mux;
  logic [DATA_WIDTH-1:0]      w_len, w_len_nz;
  logic                       unused_ok;

  assign w_pol    = SRAM_RD_DAT[31];
  assign w_end    = SRAM_RD_DAT[30];
  assign w_lsta   = SRAM_RD_DAT[29];
  assign w_lsto   = SRAM_RD_DAT[28];
  assign w_mux    = SRAM_RD_DAT[27:24];
  assign w_len    = SRAM_RD_DAT[DATA_WIDTH-1:0];
  assign w_len_nz = (w_len == '0) ? DATA_WIDTH'(1) : w_len;

  // Pointer arithmetic wraps at the SRAM address width, not the pointer width.
  assign addr_inc  = ptr[SRAM_ADDR_WIDTH-1:0] + SRAM_ADDR_WIDTH'(1);
  assign ptr_inc   = CMD_WIDTH'(addr_inc);
  assign SRAM_ADDR = ptr[SRAM_ADDR_WIDTH-1:0];

  // Decoded mux selection is held for downstream taps only.
  assign unused_ok = ^mux_onehot;

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_d;
  end

  // The word is decoded on the edge leaving W2, so fetch overhead is exactly two clocks.
  always_comb begin
    state_d      = state;
    ptr_d        = ptr;
    loop_addr_d  = loop_addr;
    loop_cnt_d   = loop_cnt;
    cnt_d        = cnt;
    mux_onehot_d = mux_onehot;
    loop_sto_d   = loop_sto;
    out_d        = OUT;
    done_d       = DONE;
    case (state)
      IDLE: begin
        if (START) begin
          done_d  = 1'b0;
          state_d = W1;
        end
      end
      W1: state_d = W2;
      W2: begin
        if (w_end) begin
          out_d   = 1'b0;
          done_d  = 1'b1;
          ptr_d   = '0;
          state_d = IDLE;
        end else if (w_lsta) begin
          loop_cnt_d  = LOOP_WIDTH'(w_len_nz);
          loop_addr_d = ptr_inc;
          ptr_d       = ptr_inc;
          state_d     = W1;
        end else begin
          out_d        = w_pol;
          cnt_d        = w_len_nz;
          mux_onehot_d = MUX_WIDTH'(1) << w_mux;
          loop_sto_d   = w_lsto;
          state_d      = COUNT;
        end
      end
      COUNT: begin
        if (cnt <= DATA_WIDTH'(1)) begin
          if (loop_sto && (loop_cnt > LOOP_WIDTH'(1))) begin
            loop_cnt_d = loop_cnt - LOOP_WIDTH'(1);
            ptr_d      = loop_addr;
          end else begin
            if (loop_sto) loop_cnt_d = '0;
            ptr_d = ptr_inc;
          end
          state_d = W1;
        end else begin
          cnt_d = cnt - DATA_WIDTH'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      ptr                   <= '0;
      loop_addr             <= '0;
      loop_cnt              <= '0;
      cnt                   <= '0;
      mux_onehot            <= '0;
      loop_sto              <= 1'b0;
      OUT                   <= 1'b0;
      DONE                  <= 1'b0;
      sim_changed_sram_addr <= 1'b0;
    end else begin
      ptr                   <= ptr_d;
      loop_addr             <= loop_addr_d;
      loop_cnt              <= loop_cnt_d;
      cnt                   <= cnt_d;
      mux_onehot            <= mux_onehot_d;
      loop_sto              <= loop_sto_d;
      OUT                   <= out_d;
      DONE                  <= done_d;
      sim_changed_sram_addr <= (ptr_d[SRAM_ADDR_WIDTH-1:0] != ptr[SRAM_ADDR_WIDTH-1:0]);
    end
  end

endmodule

// File: tb/tb_nmr_bstrm_simp_cnt.sv
// tb/tb_nmr_bstrm_simp_cnt.sv - self-checking bench for nmr_bstrm_simp_cnt
// Word-level program interpreter predicts OUT/DONE/SRAM_ADDR/pulse per clock.
module tb_nmr_bstrm_simp_cnt;

  logic        CLK = 1'b0;
  logic        RST;
  logic        START;
  logic        DONE;
  logic        OUT;
  logic [7:0]  SRAM_ADDR;
  logic [31:0] SRAM_RD_DAT;
  logic        sim_changed_sram_addr;

  logic [31:0] mem [256];
  int checks = 0;
  int errors = 0;

  int m_lc;
  int m_la;
  bit eo[$];
  int ea[$];
  bit ed[$];
  bit ended;

  always #5 CLK = ~CLK;

  assign SRAM_RD_DAT = mem[SRAM_ADDR];

  nmr_bstrm_simp_cnt dut (
    .CLK                   (CLK),
    .RST                   (RST),
    .START                 (START),
    .DONE                  (DONE),
    .OUT                   (OUT),
    .SRAM_ADDR             (SRAM_ADDR),
    .SRAM_RD_DAT           (SRAM_RD_DAT),
    .sim_changed_sram_addr (sim_changed_sram_addr)
  );

  function automatic logic [31:0] mk(bit pol, bit se, bit ls, bit lt, int len);
    logic [3:0] mx;
    mx = 4'($urandom_range(0, 15));
    return {pol, se, ls, lt, mx, 24'(len)};
  endfunction

  function automatic void push(int cap, int a, bit o, bit d);
    if (eo.size() < cap) begin
      eo.push_back(o);
      ea.push_back(a);
      ed.push_back(d);
    end
  endfunction

  // Interprets the program: each word costs 2 fetch clocks, a segment then holds for len clocks.
  function automatic void build_model(int cap);
    int a;
    bit o;
    int n;
    int len;
    logic [31:0] w;
    eo.delete(); ea.delete(); ed.delete();
    ended = 1'b0;
    a = 0;
    o = 1'b0;
    while (eo.size() < cap) begin
      push(cap, a, o, 1'b0);
      push(cap, a, o, 1'b0);
      if (eo.size() >= cap) break;
      w   = mem[a];
      len = int'(w[23:0]);
      if (w[30]) begin
        ended = 1'b1;
        for (int i = 0; i < 3; i++) push(cap, 0, 1'b0, 1'b1);
        break;
      end else if (w[29]) begin
        m_lc = (len == 0) ? 1 : len;
        a    = (a + 1) % 256;
        m_la = a;
      end else begin
        o = w[31];
        n = (len == 0) ? 1 : len;
        for (int i = 0; i < n; i++) push(cap, a, o, 1'b0);
        if (w[28] && m_lc > 1) begin
          m_lc = m_lc - 1;
          a    = m_la;
        end else begin
          if (w[28]) m_lc = 0;
          a = (a + 1) % 256;
        end
      end
    end
  endfunction

  task automatic do_reset();
    @(negedge CLK);
    RST   = 1'b1;
    START = 1'b0;
    @(negedge CLK);
    RST  = 1'b0;
    m_lc = 0;
    m_la = 0;
  endtask

  task automatic run_check(input string name, input int cap, input int poke,
                           output int first_rise, output int jumps65, output int wraps);
    int prev_exp;
    int prev_obs;
    bit exp_sim;
    build_model(cap);
    first_rise = -1;
    jumps65    = 0;
    wraps      = 0;
    prev_exp   = 0;
    prev_obs   = 0;
    @(negedge CLK);
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    for (int k = 0; k < eo.size(); k++) begin
      if (k > 0) @(negedge CLK);
      exp_sim = (ea[k] != prev_exp);
      checks++;
      if (OUT !== eo[k] || SRAM_ADDR !== 8'(ea[k]) || DONE !== ed[k] ||
          sim_changed_sram_addr !== exp_sim) begin
        errors++;
        $display("FAIL %s cycle %0d: got out=%b addr=%0d done=%b pulse=%b, want out=%b addr=%0d done=%b pulse=%b",
                 name, k, OUT, SRAM_ADDR, DONE, sim_changed_sram_addr,
                 eo[k], ea[k], ed[k], exp_sim);
      end
      prev_exp = ea[k];
      if (first_rise < 0 && OUT === 1'b1) first_rise = k;
      if (prev_obs == 6 && SRAM_ADDR === 8'd5) jumps65++;
      if (prev_obs == 255 && SRAM_ADDR === 8'd0) wraps++;
      prev_obs = int'(SRAM_ADDR);
      START = (k == poke);
    end
    START = 1'b0;
    if (!ended) do_reset();
  endtask

  function automatic void clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 32'h4000_0000;
  endfunction

  function automatic void load_directed();
    clear_mem();
    mem[0] = mk(1, 0, 0, 0, 4);
    mem[1] = mk(0, 0, 0, 0, 4);
    mem[2] = mk(1, 0, 0, 0, 7);
    mem[3] = mk(0, 0, 0, 0, 8);
    mem[4] = mk(0, 0, 1, 0, 5);
    mem[5] = mk(1, 0, 0, 0, 9);
    mem[6] = mk(0, 0, 0, 1, 9);
    mem[7] = mk(0, 1, 0, 0, 16);
  endfunction

  task automatic test_reset();
    do_reset();
    for (int k = 0; k < 10; k++) begin
      checks++;
      if (OUT !== 1'b0 || DONE !== 1'b0 || SRAM_ADDR !== 8'd0 || sim_changed_sram_addr !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle cycle %0d: got out=%b done=%b addr=%0d pulse=%b, want all zero",
                 k, OUT, DONE, SRAM_ADDR, sim_changed_sram_addr);
      end
      @(negedge CLK);
    end
  endtask

  task automatic test_directed();
    int fr, j65, wr;
    load_directed();
    run_check("directed", 4000, -1, fr, j65, wr);
    checks++;
    if (fr !== 2) begin
      errors++;
      $display("FAIL first_out_rise: got cycle %0d, want 2", fr);
    end
    checks++;
    if (j65 !== 4) begin
      errors++;
      $display("FAIL loop_jumps: got %0d jumps 6->5, want 4", j65);
    end
  endtask

  task automatic test_replay();
    int fr, j65, wr;
    run_check("replay", 4000, 8, fr, j65, wr);
    checks++;
    if (j65 !== 4) begin
      errors++;
      $display("FAIL replay_loop_jumps: got %0d, want 4", j65);
    end
  endtask

  task automatic test_boundary();
    int fr, j65, wr;
    clear_mem();
    mem[0] = mk(1, 0, 0, 1, 0);
    mem[1] = mk(0, 0, 1, 0, 0);
    mem[2] = mk(0, 0, 0, 1, 2);
    mem[3] = mk(1, 0, 0, 0, 0);
    mem[4] = mk(1, 1, 1, 1, 3);
    run_check("boundary", 4000, -1, fr, j65, wr);
  endtask

  task automatic test_reset_mid();
    int fr, j65, wr;
    load_directed();
    run_check("reset_mid_pre", 40, -1, fr, j65, wr);
    checks++;
    if (OUT !== 1'b0 || DONE !== 1'b0 || SRAM_ADDR !== 8'd0 || sim_changed_sram_addr !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: got out=%b done=%b addr=%0d pulse=%b, want all zero",
               OUT, DONE, SRAM_ADDR, sim_changed_sram_addr);
    end
    run_check("reset_mid_restart", 4000, -1, fr, j65, wr);
  endtask

  task automatic test_wrap();
    int fr, j65, wr;
    for (int i = 0; i < 256; i++) mem[i] = mk(i[0], 0, 0, 0, 0);
    run_check("wrap", 790, -1, fr, j65, wr);
    checks++;
    if (wr !== 1) begin
      errors++;
      $display("FAIL addr_wrap: got %0d wraps 255->0, want 1", wr);
    end
  endtask

  task automatic test_random();
    int fr, j65, wr;
    int n, r, poke;
    for (int it = 0; it < 8; it++) begin
      clear_mem();
      n = $urandom_range(3, 12);
      for (int i = 0; i < n - 1; i++) begin
        r = $urandom_range(0, 9);
        if (r < 2)      mem[i] = mk(1'($urandom), 0, 1, 0, $urandom_range(0, 4));
        else if (r < 4) mem[i] = mk(1'($urandom), 0, 0, 1, $urandom_range(0, 6));
        else            mem[i] = mk(1'($urandom), 0, 0, 0, $urandom_range(0, 6));
      end
      mem[n-1] = mk(0, 1, 0, 0, $urandom_range(0, 20));
      poke = $urandom_range(3, 6);
      run_check("random", 4000, poke, fr, j65, wr);
    end
  endtask

  initial begin
    RST   = 1'b1;
    START = 1'b0;
    m_lc  = 0;
    m_la  = 0;
    clear_mem();
    test_reset();
    test_directed();
    test_replay();
    test_boundary();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
